// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the Lab 4 multicycle MIPS controller: opcodes, functs,
// datapath select codes and the FSM state type.
package mips_ctrl_pkg;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpXori  = 6'b001110;
  localparam logic [5:0] OpAddi  = 6'b001000;

  localparam logic [5:0] FnJr  = 6'b001000;
  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnSlt = 6'b101010;

  localparam logic [1:0] PcSrcAlu    = 2'd0;
  localparam logic [1:0] PcSrcAluOut = 2'd1;
  localparam logic [1:0] PcSrcJump   = 2'd2;
  localparam logic [1:0] PcSrcRegA   = 2'd3;

  localparam logic [1:0] SrcBRegB   = 2'd0;
  localparam logic [1:0] SrcBFour   = 2'd1;
  localparam logic [1:0] SrcBImm    = 2'd2;
  localparam logic [1:0] SrcBImmSh2 = 2'd3;

  localparam logic [1:0] AluAdd = 2'd0;
  localparam logic [1:0] AluSub = 2'd1;
  localparam logic [1:0] AluXor = 2'd2;
  localparam logic [1:0] AluSlt = 2'd3;

  localparam logic [1:0] RegDstRt = 2'd0;
  localparam logic [1:0] RegDstRd = 2'd1;
  localparam logic [1:0] RegDstRa = 2'd2;

  localparam logic [1:0] WbAluOut = 2'd0;
  localparam logic [1:0] WbMem    = 2'd1;
  localparam logic [1:0] WbPc     = 2'd2;

  typedef enum logic [3:0] {
    StFetch, StDecode, StExR, StWbR, StExI, StWbI, StMaddr, StMrd,
    StMwb, StMwr, StBr, StJmp, StJal, StJr, StTrap
  } state_e;

endpackage

// File: rtl/multicycle_controller_alu_ctrl_decode.sv
// R-type funct to ALU operation decode; o_valid flags the arithmetic functs.
module alu_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [1:0] o_alu_op,
  output logic       o_valid
);

  always_comb begin
    o_alu_op = AluAdd;
    o_valid  = 1'b1;
    case (i_funct)
      FnAdd:   o_alu_op = AluAdd;
      FnSub:   o_alu_op = AluSub;
      FnSlt:   o_alu_op = AluSlt;
      default: o_valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback and
// drives every datapath select and strobe as a decode of the current state.
module multicycle_controller
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_we,
  output logic       reg_we,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       imm_zext,
  output logic [1:0] alu_op,
  output logic [1:0] reg_dst,
  output logic [1:0] wb_src,
  output logic       instr_done,
  output logic       halted
);

  state_e     r_state;
  state_e     w_state_next;
  logic [1:0] w_alu_op_r;
  logic       w_funct_alu;
  logic       w_br_taken;

  alu_ctrl_decode u_alu_ctrl_decode (
    .i_funct  (funct),
    .o_alu_op (w_alu_op_r),
    .o_valid  (w_funct_alu)
  );

  assign w_br_taken = (opcode == OpBeq) ? alu_zero : ~alu_zero;

  always_ff @(posedge clk) begin
    if (reset) r_state <= StFetch;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    mem_rd = 1'b0; mem_wr = 1'b0; iord = 1'b0; ir_we = 1'b0;
    pc_we = 1'b0; reg_we = 1'b0; pc_src = PcSrcAlu; alu_src_a = 1'b0;
    alu_src_b = SrcBRegB; imm_zext = 1'b0; alu_op = AluAdd; reg_dst = RegDstRt;
    wb_src = WbAluOut; instr_done = 1'b0; halted = 1'b0;
    // Outputs stay at their zero defaults for the whole reset cycle.
    if (!reset) begin
      case (r_state)
        StFetch: begin
          mem_rd = 1'b1;
          if (mem_ready) begin
            ir_we = 1'b1; pc_we = 1'b1; pc_src = PcSrcAlu;
            alu_src_b = SrcBFour; alu_op = AluAdd;
            w_state_next = StDecode;
          end
        end
        StDecode: begin
          alu_src_b = SrcBImmSh2;
          case (opcode)
            OpLw, OpSw:     w_state_next = StMaddr;
            OpAddi, OpXori: w_state_next = StExI;
            OpBeq, OpBne:   w_state_next = StBr;
            OpJ:            w_state_next = StJmp;
            OpJal:          w_state_next = StJal;
            OpRtype: begin
              if (funct == FnJr)    w_state_next = StJr;
              else if (w_funct_alu) w_state_next = StExR;
              else                  w_state_next = StTrap;
            end
            default:        w_state_next = StTrap;
          endcase
        end
        StExR: begin
          alu_src_a = 1'b1; alu_src_b = SrcBRegB; alu_op = w_alu_op_r;
          w_state_next = StWbR;
        end
        StWbR: begin
          reg_we = 1'b1; reg_dst = RegDstRd; wb_src = WbAluOut; instr_done = 1'b1;
          w_state_next = StFetch;
        end
        StExI: begin
          alu_src_a = 1'b1; alu_src_b = SrcBImm;
          if (opcode == OpXori) begin
            alu_op = AluXor; imm_zext = 1'b1;
          end
          w_state_next = StWbI;
        end
        StWbI: begin
          reg_we = 1'b1; reg_dst = RegDstRt; wb_src = WbAluOut; instr_done = 1'b1;
          w_state_next = StFetch;
        end
        StMaddr: begin
          alu_src_a = 1'b1; alu_src_b = SrcBImm;
          w_state_next = (opcode == OpLw) ? StMrd : StMwr;
        end
        StMrd: begin
          mem_rd = 1'b1; iord = 1'b1;
          if (mem_ready) w_state_next = StMwb;
        end
        StMwb: begin
          reg_we = 1'b1; reg_dst = RegDstRt; wb_src = WbMem; instr_done = 1'b1;
          w_state_next = StFetch;
        end
        StMwr: begin
          mem_wr = 1'b1; iord = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            w_state_next = StFetch;
          end
        end
        StBr: begin
          alu_src_a = 1'b1; alu_src_b = SrcBRegB; alu_op = AluSub; instr_done = 1'b1;
          if (w_br_taken) begin
            pc_we = 1'b1; pc_src = PcSrcAluOut;
          end
          w_state_next = StFetch;
        end
        StJmp: begin
          pc_we = 1'b1; pc_src = PcSrcJump; instr_done = 1'b1;
          w_state_next = StFetch;
        end
        StJal: begin
          reg_we = 1'b1; reg_dst = RegDstRa; wb_src = WbPc;
          pc_we = 1'b1; pc_src = PcSrcJump; instr_done = 1'b1;
          w_state_next = StFetch;
        end
        StJr: begin
          pc_we = 1'b1; pc_src = PcSrcRegA; instr_done = 1'b1;
          w_state_next = StFetch;
        end
        StTrap:  halted = 1'b1;
        default: w_state_next = StFetch;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: builds an expected per-cycle output trace
// from instruction-level rules, then replays it with random waits and flags.
module tb_multicycle_controller;

  localparam logic [5:0] TOpRt = 6'b000000, TOpLw = 6'b100011, TOpSw = 6'b101011;
  localparam logic [5:0] TOpJ = 6'b000010, TOpJal = 6'b000011, TOpBeq = 6'b000100;
  localparam logic [5:0] TOpBne = 6'b000101, TOpXori = 6'b001110, TOpAddi = 6'b001000;
  localparam logic [5:0] TFnJr = 6'b001000, TFnAdd = 6'b100000, TFnSub = 6'b100010;
  localparam logic [5:0] TFnSlt = 6'b101010;

  typedef struct packed {
    logic       mem_rd;
    logic       mem_wr;
    logic       iord;
    logic       ir_we;
    logic       pc_we;
    logic       reg_we;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       imm_zext;
    logic [1:0] alu_op;
    logic [1:0] reg_dst;
    logic [1:0] wb_src;
    logic       instr_done;
    logic       halted;
  } out_t;

  typedef struct {
    logic       rst;
    logic       rdy;
    logic       zero;
    logic [5:0] op;
    logic [5:0] fn;
    out_t       exp;
    int         idx;
  } step_t;

  logic clk = 1'b0;
  logic reset, alu_zero, mem_ready;
  logic [5:0] opcode, funct;
  logic mem_rd, mem_wr, iord, ir_we, pc_we, reg_we, alu_src_a, imm_zext;
  logic instr_done, halted;
  logic [1:0] pc_src, alu_src_b, alu_op, reg_dst, wb_src;
  out_t obs;

  step_t plan[$];
  logic [5:0] cur_op, cur_fn;
  int cur_idx = 0;
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .alu_zero   (alu_zero),
    .mem_ready  (mem_ready),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .iord       (iord),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .reg_we     (reg_we),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .imm_zext   (imm_zext),
    .alu_op     (alu_op),
    .reg_dst    (reg_dst),
    .wb_src     (wb_src),
    .instr_done (instr_done),
    .halted     (halted)
  );

  assign obs = {mem_rd, mem_wr, iord, ir_we, pc_we, reg_we, pc_src, alu_src_a, alu_src_b,
                imm_zext, alu_op, reg_dst, wb_src, instr_done, halted};

  task automatic check_eq(input string tag, input out_t got, input out_t exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %05h expected %05h", tag, got, exp);
  endtask

  function automatic logic rbit();
    return $urandom_range(0, 1) != 0;
  endfunction

  function automatic logic legal_op(input logic [5:0] op);
    return op inside {TOpRt, TOpLw, TOpSw, TOpJ, TOpJal, TOpBeq, TOpBne, TOpXori, TOpAddi};
  endfunction

  // One cycle of the plan; IR fields are junk until the instruction is fetched.
  task automatic step(input logic rdy, input logic zero, input logic ir_valid, input out_t e);
    step_t s;
    s.rst = 1'b0; s.rdy = rdy; s.zero = zero; s.exp = e; s.idx = cur_idx;
    s.op = ir_valid ? cur_op : 6'($urandom);
    s.fn = ir_valid ? cur_fn : 6'($urandom);
    plan.push_back(s);
  endtask

  task automatic step_reset();
    step_t s;
    s.rst = 1'b1; s.rdy = rbit(); s.zero = rbit(); s.exp = '0; s.idx = cur_idx;
    s.op = 6'($urandom); s.fn = 6'($urandom);
    plan.push_back(s);
  endtask

  // Expected trace of one instruction from the instruction-level rules.
  task automatic add_instr(input logic [5:0] op, input logic [5:0] fn, input int fwait,
                           input int mwait, input logic abort, input logic zforce,
                           input logic zval);
    out_t e;
    logic z;
    logic is_alu_r, is_mem;
    cur_op = op; cur_fn = fn; cur_idx++;
    is_alu_r = (op == TOpRt) && (fn inside {TFnAdd, TFnSub, TFnSlt});
    is_mem = (op == TOpLw) || (op == TOpSw);
    for (int i = 0; i < fwait; i++) begin
      e = '0; e.mem_rd = 1'b1; step(1'b0, rbit(), 1'b0, e);
    end
    e = '0; e.mem_rd = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1; e.alu_src_b = 2'd1;
    step(1'b1, rbit(), 1'b0, e);
    e = '0; e.alu_src_b = 2'd3; step(rbit(), rbit(), 1'b1, e);
    if (is_mem) begin
      e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; step(rbit(), rbit(), 1'b1, e);
      e = '0; e.iord = 1'b1;
      if (op == TOpLw) e.mem_rd = 1'b1; else e.mem_wr = 1'b1;
      for (int i = 0; i < mwait; i++) step(1'b0, rbit(), 1'b1, e);
      if (abort) begin
        step_reset();
        return;
      end
      if (op == TOpSw) e.instr_done = 1'b1;
      step(1'b1, rbit(), 1'b1, e);
      if (op == TOpLw) begin
        e = '0; e.reg_we = 1'b1; e.wb_src = 2'd1; e.instr_done = 1'b1;
        step(rbit(), rbit(), 1'b1, e);
      end
    end else if (is_alu_r) begin
      e = '0; e.alu_src_a = 1'b1;
      e.alu_op = (fn == TFnSub) ? 2'd1 : (fn == TFnSlt) ? 2'd3 : 2'd0;
      step(rbit(), rbit(), 1'b1, e);
      e = '0; e.reg_we = 1'b1; e.reg_dst = 2'd1; e.instr_done = 1'b1;
      step(rbit(), rbit(), 1'b1, e);
    end else if (op == TOpAddi || op == TOpXori) begin
      e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
      if (op == TOpXori) begin e.alu_op = 2'd2; e.imm_zext = 1'b1; end
      step(rbit(), rbit(), 1'b1, e);
      e = '0; e.reg_we = 1'b1; e.instr_done = 1'b1; step(rbit(), rbit(), 1'b1, e);
    end else if (op == TOpBeq || op == TOpBne) begin
      z = zforce ? zval : rbit();
      e = '0; e.alu_src_a = 1'b1; e.alu_op = 2'd1; e.instr_done = 1'b1;
      if ((op == TOpBeq) == z) begin e.pc_we = 1'b1; e.pc_src = 2'd1; end
      step(rbit(), z, 1'b1, e);
    end else if (op == TOpJ) begin
      e = '0; e.pc_we = 1'b1; e.pc_src = 2'd2; e.instr_done = 1'b1;
      step(rbit(), rbit(), 1'b1, e);
    end else if (op == TOpJal) begin
      e = '0; e.reg_we = 1'b1; e.reg_dst = 2'd2; e.wb_src = 2'd2;
      e.pc_we = 1'b1; e.pc_src = 2'd2; e.instr_done = 1'b1;
      step(rbit(), rbit(), 1'b1, e);
    end else if (op == TOpRt && fn == TFnJr) begin
      e = '0; e.pc_we = 1'b1; e.pc_src = 2'd3; e.instr_done = 1'b1;
      step(rbit(), rbit(), 1'b1, e);
    end else begin
      e = '0; e.halted = 1'b1;
      for (int i = 0; i < 10; i++) step(rbit(), rbit(), 1'b1, e);
      step_reset();
    end
  endtask

  initial begin
    logic [5:0] legal_ops [12];
    logic [5:0] legal_fns [12];
    logic [5:0] op, fn;
    int k;
    legal_ops = '{TOpLw, TOpSw, TOpJ, TOpJal, TOpBeq, TOpBne, TOpXori, TOpAddi,
                  TOpRt, TOpRt, TOpRt, TOpRt};
    legal_fns = '{6'h0, 6'h0, 6'h0, 6'h0, 6'h0, 6'h0, 6'h0, 6'h0,
                  TFnAdd, TFnSub, TFnSlt, TFnJr};
    reset = 1'b1; mem_ready = 1'b0; alu_zero = 1'b0; opcode = '0; funct = '0;

    step_reset(); step_reset();
    add_instr(TOpRt, TFnAdd, 0, 0, 1'b0, 1'b0, 1'b0);
    add_instr(TOpLw, 6'h15, 0, 2, 1'b0, 1'b0, 1'b0);
    add_instr(TOpBeq, 6'h00, 0, 0, 1'b0, 1'b1, 1'b1);
    add_instr(TOpBne, 6'h00, 0, 0, 1'b0, 1'b1, 1'b1);
    add_instr(TOpJal, 6'h3a, 0, 0, 1'b0, 1'b0, 1'b0);
    add_instr(6'b111111, 6'h00, 0, 0, 1'b0, 1'b0, 1'b0);
    add_instr(TOpSw, 6'h00, 1, 1, 1'b1, 1'b0, 1'b0);
    add_instr(TOpXori, 6'h07, 2, 0, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 49);
      if (k < 48) begin
        op = legal_ops[k % 12];
        fn = (op == TOpRt) ? legal_fns[k % 12] : 6'($urandom);
      end else if (k == 48) begin
        op = 6'($urandom);
        if (legal_op(op)) op = 6'b111111;
        fn = 6'($urandom);
      end else begin
        op = TOpRt;
        fn = 6'($urandom);
        if (fn inside {TFnAdd, TFnSub, TFnSlt, TFnJr}) fn = 6'b111111;
      end
      add_instr(op, fn, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                (op == TOpSw) && ($urandom_range(0, 9) == 0), 1'b0, 1'b0);
    end

    foreach (plan[i]) begin
      @(negedge clk);
      reset = plan[i].rst; mem_ready = plan[i].rdy; alu_zero = plan[i].zero;
      opcode = plan[i].op; funct = plan[i].fn;
      #1;
      check_eq($sformatf("instr%0d/cyc%0d", plan[i].idx, i), obs, plan[i].exp);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multicycle control FSM for the Lab 4 MIPS subset: LW, SW, J, JAL, BEQ, BNE, XORI, ADDI, and R-type ADD/SUB/SLT/JR. It sequences the shared datapath through fetch, decode, execute, memory and writeback. It drives every mux select and write strobe, and handshakes with a single shared instruction/data memory. It resolves BEQ/BNE from the ALU zero flag and owns PC update.

## Interface
Parameters:
- none; all encodings come from the shared package.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `opcode`  in  6  IR[31:26]; valid from DECODE onward.
- `funct`  in  6  IR[5:0].
- `alu_zero`  in  1  ALU result == 0, combinational from the current ALU inputs.
- `mem_ready`  in  1  memory completes the pending access at this edge.
- `mem_rd` / `mem_wr`  out  1 each  memory request strobes.
- `iord`  out  1  address select: 0 = PC, 1 = ALUOut.
- `ir_we`, `pc_we`, `reg_we`  out  1 each  write enables.
- `pc_src`  out  2  PC source: 0 = ALU (PC+4), 1 = ALUOut (branch target), 2 = jump target, 3 = register A.
- `alu_src_a`  out  1  ALU input A: 0 = PC, 1 = register A.
- `alu_src_b`  out  2  ALU input B: 0 = register B, 1 = constant 4, 2 = immediate, 3 = immediate<<2.
- `imm_zext`  out  1  immediate extension: 1 = zero-extend (XORI), 0 = sign-extend.
- `alu_op`  out  2  0 = ADD, 1 = SUB, 2 = XOR, 3 = SLT.
- `reg_dst`  out  2  destination register: 0 = rt, 1 = rd, 2 = r31.
- `wb_src`  out  2  writeback source: 0 = ALUOut, 1 = memory data, 2 = PC.
- `instr_done`  out  1  one-cycle pulse on the final cycle of each instruction.
- `halted`  out  1  high in TRAP.

## Operation
- Outputs are a combinational decode of state, `opcode`, `funct`, `mem_ready` and `alu_zero`.
- Every strobe and select not listed for a state is 0.

States and actions:
- FETCH
  - Drives `mem_rd`=1, `iord`=0.
  - On `mem_ready`: `ir_we`=1, `pc_we`=1, `pc_src`=0, with ALU = PC+4 (`alu_src_a`=0, `alu_src_b`=1, ADD); then go to DECODE.
  - Otherwise hold in FETCH.
- DECODE
  - ALU = PC + (imm<<2), ADD; ALUOut captures the branch target.
  - Dispatch: LW/SW→MADDR; ADD/SUB/SLT→EXR; JR→JR; ADDI/XORI→EXI; BEQ/BNE→BR; J→JMP; JAL→JAL.
  - Any other opcode, or an R-type with any other funct, → TRAP.
- EXR
  - A op B, with `alu_op` taken from `funct`.
  - Next: WBR (`reg_we`, `reg_dst`=rd, `wb_src`=ALUOut), then FETCH.
- EXI
  - A op imm (`alu_src_b`=2); ADDI uses ADD with `imm_zext`=0; XORI uses XOR with `imm_zext`=1.
  - Next: WBI (`reg_we`, `reg_dst`=rt), then FETCH.
- MADDR
  - A + sign-extended imm.
  - Next: MRD for LW, MWR for SW.
- MRD
  - `mem_rd`=1, `iord`=1, held until `mem_ready`; then go to MWB.
  - MWB: `reg_we`, `reg_dst`=rt, `wb_src`=mem; then FETCH.
- MWR
  - `mem_wr`=1, `iord`=1, held until `mem_ready`; then FETCH.
- BR
  - A − B, SUB.
  - taken = BEQ ? `alu_zero` : !`alu_zero`.
  - If taken: `pc_we`=1, `pc_src`=1. Go to FETCH either way.
- JMP
  - `pc_we`=1, `pc_src`=2; then FETCH.
- JAL
  - Writes the link and jumps in the same cycle: `reg_we`=1, `reg_dst`=r31, `wb_src`=PC (already PC+4), plus `pc_we`=1, `pc_src`=2.
  - Then FETCH.
- JR
  - `pc_we`=1, `pc_src`=3; then FETCH.
- TRAP
  - `halted`=1, all strobes 0.
  - Stays in TRAP until `reset`.
- `instr_done` is asserted in WBR, WBI, MWB, BR, JMP, JAL and JR, and in MWR on the cycle `mem_ready`=1.

## Timing
- Reset
  - While `reset` is high, all outputs are forced to 0 (including `halted` and `instr_done`).
  - The state becomes FETCH at the edge.
  - Reset mid-access abandons the request: the strobe drops in the reset cycle itself.
- Cycles per instruction with zero-wait memory:
  - BEQ/BNE/J/JAL/JR: 3.
  - ADD/SUB/SLT/ADDI/XORI/SW: 4.
  - LW: 5.
  - Each cycle with `mem_ready`=0 during FETCH, MRD or MWR adds one cycle.
- Memory handshake
  - A request stays asserted, with `iord` stable, until `mem_ready` is sampled high.
  - `mem_ready` is ignored when no request is asserted.
  - `mem_rd` and `mem_wr` are never both high.
- Branch decision uses `alu_zero` in the BR cycle only.

## Structure
- Package `mips_ctrl_pkg` holds:
  - opcode and funct defines (LW=100011, SW=101011, J=000010, JAL=000011, BEQ=000100, BNE=000101, XORI=001110, ADDI=001000, RTYPE=000000; JR=001000, ADD=100000, SUB=100010, SLT=101010);
  - state encoding;
  - `pc_src`, `alu_src_b`, `alu_op`, `reg_dst` and `wb_src` encodings.
- Sub-module `alu_ctrl_decode`: combinational funct → `alu_op`, instantiated once.

## Test plan
- ADD (funct 100000), `mem_ready` tied 1:
  - FETCH→DECODE→EXR→WBR→FETCH.
  - `reg_we`=1 and `reg_dst`=1 in WBR only.
  - `instr_done` pulses at cycle 4.
- LW with `mem_ready` low for 2 cycles in MRD:
  - `mem_rd`=1, `iord`=1 held for 3 cycles.
  - 7 cycles total; `wb_src`=1 in MWB.
- BEQ, `alu_zero`=1 → `pc_we`=1, `pc_src`=1 in BR.
  - BNE, `alu_zero`=1 → `pc_we`=0.
  - Both take 3 cycles.
- JAL → a single cycle with `reg_we`=1, `reg_dst`=2, `wb_src`=2, `pc_we`=1, `pc_src`=2.
- Opcode 111111 → TRAP, `halted`=1, no strobes for 10 cycles; `reset` → FETCH.
- `reset` asserted during MWR with `mem_wr`=1 → `mem_wr`=0 the same cycle; FETCH the next cycle.
